iob_wb2iob_m: RTL and testbench

- Bridges the Ethernet MAC's Wishbone master (descriptor/buffer DMA) port onto the IOb-bus as an IOb master, so the MAC can read and write system memory.
- Reverse direction of the existing IOb-to-Wishbone slave adapter: Wishbone slave side faces the MAC master port; IOb master side faces the memory interconnect.
- Allows a single outstanding transfer.
- Adds an address-window check and a response timeout, both reported through wb_err_o.

---
 rtl/iob_wb2iob_m_pkg.sv | 13 +
 rtl/iob_wb2iob_m_if.sv | 34 +++
 rtl/iob_wb2iob_timeout.sv | 32 +++
 rtl/iob_wb2iob_m.sv | 163 ++++++++++++++++
 tb/tb_iob_wb2iob_m.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/iob_wb2iob_m_pkg.sv
// Shared types and constants for the Wishbone-slave to IOb-master bridge.
package iob_wb2iob_m_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK  = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  localparam logic [1:0] WORD_ALIGN_LSB = 2'b00;

endpackage

// File: rtl/iob_wb2iob_m_if.sv
// Bus bundle for the bridge: Wishbone slave side (MAC facing) and IOb master side.
interface iob_wb2iob_m_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic [31:0]         wb_adr_i;
  logic [DATA_W/8-1:0] wb_sel_i;
  logic                wb_we_i;
  logic [DATA_W-1:0]   wb_dat_i;
  logic [DATA_W-1:0]   wb_dat_o;
  logic                wb_cyc_i;
  logic                wb_stb_i;
  logic                wb_ack_o;
  logic                wb_err_o;

  logic                valid;
  logic [ADDR_W-1:0]   address;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic [DATA_W-1:0]   rdata;
  logic                ready;

  modport slave (
    input  wb_adr_i, wb_sel_i, wb_we_i, wb_dat_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );

  modport master (
    output valid, address, wdata, wstrb,
    input  rdata, ready
  );

endinterface

// File: rtl/iob_wb2iob_timeout.sv
// Response timeout counter; o_expired flags the cycle whose increment reaches all-ones.
module iob_wb2iob_timeout #(
  parameter int TIMEOUT_W = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [TIMEOUT_W-1:0] CNT_MAX = {TIMEOUT_W{1'b1}};

  logic [TIMEOUT_W-1:0] r_cnt;
  logic [TIMEOUT_W-1:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + TIMEOUT_W'(1);
  assign o_expired = i_en && (w_cnt_inc == CNT_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= {TIMEOUT_W{1'b0}};
    end else if (i_clr) begin
      r_cnt <= {TIMEOUT_W{1'b0}};
    end else if (i_en) begin
      r_cnt <= w_cnt_inc;
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/iob_wb2iob_m.sv
// Wishbone slave (MAC DMA master) to IOb master bridge, one transfer outstanding,
// with address-window and response-timeout errors reported on wb_err_o.
module iob_wb2iob_m
  import iob_wb2iob_m_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter int          DATA_W    = 32,
  parameter logic [31:0] HI_ADDR   = 32'd0,
  parameter int          TIMEOUT_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  iob_wb2iob_m_if.slave    wb,
  iob_wb2iob_m_if.master   iob
);

  localparam int STRB_W = DATA_W / 8;

  state_t              r_state, w_state_nxt;
  logic                r_valid, w_valid_nxt;
  logic [ADDR_W-1:0]   r_address, w_address_nxt;
  logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;
  logic [STRB_W-1:0]   r_wstrb, w_wstrb_nxt;
  logic [DATA_W-1:0]   r_dat, w_dat_nxt;
  logic                r_ack, w_ack_nxt;
  logic                r_err, w_err_nxt;
  logic                r_abort, w_abort_nxt;
  logic                w_abort_now;
  logic                w_win_ok;
  logic                w_cnt_clr, w_cnt_en, w_expired;
  logic                w_unused;

  // Byte lanes are expressed through wb_sel_i, so the low address bits carry no information.
  assign w_unused = ^wb.wb_adr_i[1:0];

  if (ADDR_W < 32) begin : g_window
    assign w_win_ok = (wb.wb_adr_i[31:ADDR_W] == HI_ADDR[31-ADDR_W:0]);
  end else begin : g_no_window
    assign w_win_ok = 1'b1;
  end

  if (TIMEOUT_W > 0) begin : g_tmo
    iob_wb2iob_timeout #(.TIMEOUT_W(TIMEOUT_W)) u_tmo (
      .clk       (clk),
      .rst       (rst),
      .i_clr     (w_cnt_clr),
      .i_en      (w_cnt_en),
      .o_expired (w_expired)
    );
  end else begin : g_no_tmo
    assign w_expired = 1'b0;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_valid_nxt   = r_valid;
    w_address_nxt = r_address;
    w_wdata_nxt   = r_wdata;
    w_wstrb_nxt   = r_wstrb;
    w_dat_nxt     = r_dat;
    w_ack_nxt     = 1'b0;
    w_err_nxt     = 1'b0;
    w_abort_nxt   = r_abort;
    w_cnt_clr     = 1'b1;
    w_cnt_en      = 1'b0;
    w_abort_now   = r_abort | ~wb.wb_cyc_i;
    case (r_state)
      ST_IDLE: begin
        w_abort_nxt = 1'b0;
        if (wb.wb_cyc_i && wb.wb_stb_i) begin
          if (!w_win_ok) begin
            w_state_nxt = ST_ERR;
            w_err_nxt   = 1'b1;
          end else begin
            w_state_nxt   = ST_REQ;
            w_valid_nxt   = 1'b1;
            w_address_nxt = {wb.wb_adr_i[ADDR_W-1:2], WORD_ALIGN_LSB};
            w_wdata_nxt   = wb.wb_dat_i;
            w_wstrb_nxt   = wb.wb_we_i ? wb.wb_sel_i : {STRB_W{1'b0}};
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_REQ: begin
        w_cnt_clr   = 1'b0;
        w_cnt_en    = 1'b1;
        w_abort_nxt = w_abort_now;
        // An abandoned cycle still has to drain the IOb transfer, then retires silently.
        if (iob.ready) begin
          w_valid_nxt = 1'b0;
          if (w_abort_now) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_ACK;
            w_ack_nxt   = 1'b1;
            if (r_wstrb == {STRB_W{1'b0}}) begin
              w_dat_nxt = iob.rdata;
            end else begin
              w_dat_nxt = r_dat;
            end
          end
        end else if (w_expired) begin
          w_valid_nxt = 1'b0;
          w_wstrb_nxt = {STRB_W{1'b0}};
          if (w_abort_now) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_ERR;
            w_err_nxt   = 1'b1;
          end
        end else begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_ACK:  w_state_nxt = ST_IDLE;
      ST_ERR:  w_state_nxt = ST_IDLE;
      default: begin
        w_state_nxt = ST_IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid   <= 1'b0;
      r_address <= {ADDR_W{1'b0}};
      r_wdata   <= {DATA_W{1'b0}};
      r_wstrb   <= {STRB_W{1'b0}};
      r_dat     <= {DATA_W{1'b0}};
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_abort   <= 1'b0;
    end else begin
      r_valid   <= w_valid_nxt;
      r_address <= w_address_nxt;
      r_wdata   <= w_wdata_nxt;
      r_wstrb   <= w_wstrb_nxt;
      r_dat     <= w_dat_nxt;
      r_ack     <= w_ack_nxt;
      r_err     <= w_err_nxt;
      r_abort   <= w_abort_nxt;
    end
  end

  assign iob.valid    = r_valid;
  assign iob.address  = r_address;
  assign iob.wdata    = r_wdata;
  assign iob.wstrb    = r_wstrb;
  assign wb.wb_dat_o  = r_dat;
  assign wb.wb_ack_o  = r_ack;
  assign wb.wb_err_o  = r_err;

endmodule

// File: tb/tb_iob_wb2iob_m.sv
// Directed bench for iob_wb2iob_m: 16-bit IOb window, 4-bit timeout.
module tb_iob_wb2iob_m;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  iob_wb2iob_m_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  iob_wb2iob_m #(
    .ADDR_W    (16),
    .DATA_W    (32),
    .HI_ADDR   (32'd0),
    .TIMEOUT_W (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus),
    .iob (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wb_req(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                        input logic [31:0] dat);
    bus.wb_adr_i = adr;
    bus.wb_we_i  = we;
    bus.wb_sel_i = sel;
    bus.wb_dat_i = dat;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
  endtask

  task automatic wb_idle();
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    bus.wb_adr_i = 32'd0;
    bus.wb_sel_i = 4'd0;
    bus.wb_we_i  = 1'b0;
    bus.wb_dat_i = 32'd0;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.rdata    = 32'd0;
    bus.ready    = 1'b0;
    #3;
    chk("rst_valid", {31'd0, bus.valid}, 32'd0);
    chk("rst_ack",   {31'd0, bus.wb_ack_o}, 32'd0);
    chk("rst_err",   {31'd0, bus.wb_err_o}, 32'd0);
    chk("rst_addr",  {16'd0, bus.address}, 32'd0);
    chk("rst_wstrb", {28'd0, bus.wstrb}, 32'd0);
    chk("rst_dat",   bus.wb_dat_o, 32'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Write, ready two cycles after valid rises
    wb_req(32'h0000_0104, 1'b1, 4'b0011, 32'hDEAD_BEEF);
    tick();
    chk("wr_valid", {31'd0, bus.valid}, 32'd1);
    chk("wr_addr",  {16'd0, bus.address}, 32'h0000_0104);
    chk("wr_wstrb", {28'd0, bus.wstrb}, 32'd3);
    chk("wr_wdata", bus.wdata, 32'hDEAD_BEEF);
    chk("wr_ack_early", {31'd0, bus.wb_ack_o}, 32'd0);
    tick();
    chk("wr_hold_valid", {31'd0, bus.valid}, 32'd1);
    chk("wr_hold_addr",  {16'd0, bus.address}, 32'h0000_0104);
    bus.ready = 1'b1;
    bus.rdata = 32'hAAAA_5555;
    tick();
    bus.ready = 1'b0;
    chk("wr_ack",      {31'd0, bus.wb_ack_o}, 32'd1);
    chk("wr_err",      {31'd0, bus.wb_err_o}, 32'd0);
    chk("wr_valid_lo", {31'd0, bus.valid}, 32'd0);
    chk("wr_dat_keep", bus.wb_dat_o, 32'd0);
    tick();
    chk("wr_ack_pulse", {31'd0, bus.wb_ack_o}, 32'd0);
    chk("wr_err_after", {31'd0, bus.wb_err_o}, 32'd0);
    wb_idle();

    // Read, ready in the first request cycle
    wb_req(32'h0000_0200, 1'b0, 4'b1111, 32'h1111_1111);
    tick();
    chk("rd_valid", {31'd0, bus.valid}, 32'd1);
    chk("rd_addr",  {16'd0, bus.address}, 32'h0000_0200);
    chk("rd_wstrb", {28'd0, bus.wstrb}, 32'd0);
    bus.ready = 1'b1;
    bus.rdata = 32'h1234_5678;
    tick();
    bus.ready = 1'b0;
    bus.rdata = 32'd0;
    chk("rd_ack",       {31'd0, bus.wb_ack_o}, 32'd1);
    chk("rd_dat",       bus.wb_dat_o, 32'h1234_5678);
    chk("rd_wstrb_ack", {28'd0, bus.wstrb}, 32'd0);
    chk("rd_valid_lo",  {31'd0, bus.valid}, 32'd0);
    tick();
    chk("rd_ack_pulse", {31'd0, bus.wb_ack_o}, 32'd0);
    wb_idle();

    // Address above the 16-bit window
    wb_req(32'h0001_0000, 1'b0, 4'b1111, 32'd0);
    tick();
    chk("win_err",   {31'd0, bus.wb_err_o}, 32'd1);
    chk("win_valid", {31'd0, bus.valid}, 32'd0);
    chk("win_ack",   {31'd0, bus.wb_ack_o}, 32'd0);
    tick();
    chk("win_err_pulse", {31'd0, bus.wb_err_o}, 32'd0);
    chk("win_valid2",    {31'd0, bus.valid}, 32'd0);
    wb_idle();

    // Timeout: 15 cycles in REQ without ready
    wb_req(32'h0000_0400, 1'b1, 4'b1111, 32'h0F0F_0F0F);
    tick();
    chk("tmo_valid", {31'd0, bus.valid}, 32'd1);
    for (int i = 1; i <= 14; i++) begin
      tick();
      chk("tmo_hold_valid", {31'd0, bus.valid}, 32'd1);
      chk("tmo_no_err",     {31'd0, bus.wb_err_o}, 32'd0);
    end
    tick();
    chk("tmo_err",      {31'd0, bus.wb_err_o}, 32'd1);
    chk("tmo_valid_lo", {31'd0, bus.valid}, 32'd0);
    chk("tmo_wstrb_lo", {28'd0, bus.wstrb}, 32'd0);
    chk("tmo_no_ack",   {31'd0, bus.wb_ack_o}, 32'd0);
    tick();
    chk("tmo_err_pulse", {31'd0, bus.wb_err_o}, 32'd0);
    wb_idle();

    // Ready on the expiry edge wins over the timeout
    wb_req(32'h0000_0404, 1'b0, 4'b1111, 32'd0);
    tick();
    for (int i = 1; i <= 14; i++) begin
      tick();
    end
    chk("race_valid", {31'd0, bus.valid}, 32'd1);
    bus.ready = 1'b1;
    bus.rdata = 32'hCAFE_F00D;
    tick();
    bus.ready = 1'b0;
    chk("race_ack", {31'd0, bus.wb_ack_o}, 32'd1);
    chk("race_err", {31'd0, bus.wb_err_o}, 32'd0);
    chk("race_dat", bus.wb_dat_o, 32'hCAFE_F00D);
    tick();
    chk("race_ack_pulse", {31'd0, bus.wb_ack_o}, 32'd0);
    wb_idle();

    // Cycle abort: valid held until ready, no ack/err, data not updated
    wb_req(32'h0000_0500, 1'b0, 4'b1111, 32'd0);
    tick();
    chk("abt_valid", {31'd0, bus.valid}, 32'd1);
    tick();
    wb_idle();
    tick();
    chk("abt_hold1", {31'd0, bus.valid}, 32'd1);
    tick();
    chk("abt_hold2", {31'd0, bus.valid}, 32'd1);
    bus.ready = 1'b1;
    bus.rdata = 32'h0BAD_F00D;
    tick();
    bus.ready = 1'b0;
    chk("abt_valid_lo", {31'd0, bus.valid}, 32'd0);
    chk("abt_no_ack",   {31'd0, bus.wb_ack_o}, 32'd0);
    chk("abt_no_err",   {31'd0, bus.wb_err_o}, 32'd0);
    chk("abt_dat_keep", bus.wb_dat_o, 32'hCAFE_F00D);
    tick();
    chk("abt_no_ack2", {31'd0, bus.wb_ack_o}, 32'd0);
    chk("abt_no_err2", {31'd0, bus.wb_err_o}, 32'd0);
    wb_req(32'h0000_0307, 1'b1, 4'b1100, 32'h55AA_55AA);
    tick();
    chk("post_abt_valid", {31'd0, bus.valid}, 32'd1);
    chk("post_abt_addr",  {16'd0, bus.address}, 32'h0000_0304);
    chk("post_abt_wstrb", {28'd0, bus.wstrb}, 32'hC);
    bus.ready = 1'b1;
    tick();
    bus.ready = 1'b0;
    chk("post_abt_ack", {31'd0, bus.wb_ack_o}, 32'd1);
    chk("post_abt_dat", bus.wb_dat_o, 32'hCAFE_F00D);
    tick();
    wb_idle();

    // Asynchronous reset while a request is outstanding
    wb_req(32'h0000_0600, 1'b1, 4'b1111, 32'h7777_7777);
    tick();
    chk("ar_valid", {31'd0, bus.valid}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_valid_lo", {31'd0, bus.valid}, 32'd0);
    chk("ar_ack",      {31'd0, bus.wb_ack_o}, 32'd0);
    chk("ar_err",      {31'd0, bus.wb_err_o}, 32'd0);
    chk("ar_wstrb",    {28'd0, bus.wstrb}, 32'd0);
    wb_idle();
    tick();
    rst = 1'b1;
    tick();
    wb_req(32'h0000_0700, 1'b0, 4'b1111, 32'd0);
    tick();
    chk("ar_rd_valid", {31'd0, bus.valid}, 32'd1);
    chk("ar_rd_addr",  {16'd0, bus.address}, 32'h0000_0700);
    bus.ready = 1'b1;
    bus.rdata = 32'h8765_4321;
    tick();
    bus.ready = 1'b0;
    chk("ar_rd_ack", {31'd0, bus.wb_ack_o}, 32'd1);
    chk("ar_rd_dat", bus.wb_dat_o, 32'h8765_4321);
    tick();
    chk("ar_rd_ack_pulse", {31'd0, bus.wb_ack_o}, 32'd0);
    wb_idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
